// File: rtl/setup_menu.sv
// Keypad-driven configuration menu for the lock (responder side of the setup handshake).
// Define SETUP_MENU_TIMEOUT_EN to abort an idle menu after TIMEOUT_CYCLES clocks.
package setup_menu_pkg;

    typedef struct packed {
        logic       status;
        logic [3:0] digit1;
        logic [3:0] digit2;
        logic [3:0] digit3;
        logic [3:0] digit4;
    } pinPac_t;

    typedef struct packed {
        logic       bip_status;
        logic [6:0] bip_time;
        logic [6:0] tranca_aut_time;
        pinPac_t    master_pin;
        pinPac_t    pin1;
        pinPac_t    pin2;
        pinPac_t    pin3;
        pinPac_t    pin4;
    } setupPac_t;

    typedef struct packed {
        logic [3:0] BCD5;
        logic [3:0] BCD4;
        logic [3:0] BCD3;
        logic [3:0] BCD2;
        logic [3:0] BCD1;
        logic [3:0] BCD0;
    } bcdPac_t;

endpackage

module setup_menu
    import setup_menu_pkg::*;
#(
    parameter int         MIN_TIME       = 5,
    parameter int         MAX_TIME       = 60,
    parameter logic [3:0] KEY_CONFIRM    = 4'hF,
    parameter logic [3:0] KEY_CANCEL     = 4'hE,
    parameter int         TIMEOUT_CYCLES = 30000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       setup_on,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  setupPac_t  data_setup_old,
    output setupPac_t  data_setup_new,
    output logic       setup_end,
    output bcdPac_t    bcd_out,
    output logic       bcd_enable
);

    typedef enum logic [3:0] {
        IDLE, LOAD, S_BIPON, S_BIPT, S_TRAVT,
        S_PIN1, S_PIN2, S_PIN3, S_PIN4, DONE, WAIT_LOW
    } state_t;

    localparam logic [6:0] MIN_T = 7'(MIN_TIME);
    localparam logic [6:0] MAX_T = 7'(MAX_TIME);

    state_t          state, nstep;
    setupPac_t       work, work_nx, result;
    logic [3:0][3:0] dig;
    logic [2:0]      cnt;
    logic [6:0]      tval;
    logic            step, is_digit, confirm, cancel, tmo_hit;
    logic            adv, pin_ok, time_ok;
    bcdPac_t         disp;

    function automatic pinPac_t pin_upd(input pinPac_t p, input logic full,
                                        input logic [3:0][3:0] d);
        pin_upd = p;
        pin_upd.status = full;
        if (full) begin
            pin_upd.digit1 = d[0];
            pin_upd.digit2 = d[1];
            pin_upd.digit3 = d[2];
            pin_upd.digit4 = d[3];
        end
    endfunction

    assign step     = state inside {S_BIPON, S_BIPT, S_TRAVT, S_PIN1, S_PIN2, S_PIN3, S_PIN4};
    assign is_digit = key_code <= 4'd9;
    assign confirm  = step && key_valid && key_code == KEY_CONFIRM;
    assign cancel   = step && ((key_valid && key_code == KEY_CANCEL) || tmo_hit);
    assign tval     = 7'(dig[1]) * 7'd10 + 7'(dig[0]);
    assign time_ok  = tval >= MIN_T && tval <= MAX_T;
    assign pin_ok   = cnt == 3'd4 || (cnt == 3'd1 && dig[0] == 4'd0 && state != S_PIN1);

`ifdef SETUP_MENU_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo;
    assign tmo_hit = step && tmo == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (!rst || !step || key_valid) tmo <= '0;
        else if (!tmo_hit)              tmo <= tmo + 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        work_nx = work;
        adv     = 1'b0;
        nstep   = IDLE;
        case (state)
            S_BIPON: nstep = S_BIPT;
            S_BIPT:  nstep = S_TRAVT;
            S_TRAVT: nstep = S_PIN1;
            S_PIN1:  nstep = S_PIN2;
            S_PIN2:  nstep = S_PIN3;
            S_PIN3:  nstep = S_PIN4;
            S_PIN4:  nstep = DONE;
            default: nstep = IDLE;
        endcase
        if (confirm) begin
            if (cnt == 3'd0) adv = 1'b1;
            else case (state)
                S_BIPON: begin work_nx.bip_status = dig[0][0]; adv = 1'b1; end
                S_BIPT:  if (time_ok) begin work_nx.bip_time = tval; adv = 1'b1; end
                S_TRAVT: if (time_ok) begin work_nx.tranca_aut_time = tval; adv = 1'b1; end
                S_PIN1:  if (pin_ok) begin work_nx.pin1 = pin_upd(work.pin1, cnt == 3'd4, dig); adv = 1'b1; end
                S_PIN2:  if (pin_ok) begin work_nx.pin2 = pin_upd(work.pin2, cnt == 3'd4, dig); adv = 1'b1; end
                S_PIN3:  if (pin_ok) begin work_nx.pin3 = pin_upd(work.pin3, cnt == 3'd4, dig); adv = 1'b1; end
                S_PIN4:  if (pin_ok) begin work_nx.pin4 = pin_upd(work.pin4, cnt == 3'd4, dig); adv = 1'b1; end
                default: ;
            endcase
        end
        result = work_nx;
        result.master_pin = data_setup_old.master_pin;
    end

    always_comb begin
        disp = '1;
        case (state)
            S_BIPON, S_BIPT, S_TRAVT: begin
                disp.BCD3 = state == S_BIPON ? 4'd1 : state == S_BIPT ? 4'd2 : 4'd3;
                if (cnt >= 3'd1) disp.BCD0 = dig[0];
                if (cnt >= 3'd2) disp.BCD1 = dig[1];
            end
            S_PIN1, S_PIN2, S_PIN3, S_PIN4: begin
                if (cnt >= 3'd1) disp.BCD3 = dig[0];
                if (cnt >= 3'd2) disp.BCD2 = dig[1];
                if (cnt >= 3'd3) disp.BCD1 = dig[2];
                if (cnt >= 3'd4) disp.BCD0 = dig[3];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            work           <= '0;
            dig            <= '0;
            cnt            <= '0;
            setup_end      <= 1'b0;
            data_setup_new <= '0;
            bcd_out        <= '1;
            bcd_enable     <= 1'b0;
        end else begin
            setup_end  <= 1'b0;
            bcd_out    <= disp;
            bcd_enable <= !(state == IDLE || state == WAIT_LOW);
            // losing setup_on outranks any key, including cancel
            if (!setup_on && state != DONE && state != WAIT_LOW) begin
                state <= IDLE;
                dig   <= '0;
                cnt   <= '0;
            end else if (cancel) begin
                state          <= DONE;
                setup_end      <= 1'b1;
                data_setup_new <= data_setup_old;
                dig            <= '0;
                cnt            <= '0;
            end else case (state)
                IDLE:     if (setup_on) state <= LOAD;
                LOAD: begin
                    work  <= data_setup_old;
                    state <= S_BIPON;
                    dig   <= '0;
                    cnt   <= '0;
                end
                DONE:     state <= WAIT_LOW;
                WAIT_LOW: if (!setup_on) state <= IDLE;
                default: if (confirm) begin
                    dig <= '0;
                    cnt <= '0;
                    if (adv) begin
                        state <= nstep;
                        work  <= work_nx;
                        if (nstep == DONE) begin
                            setup_end      <= 1'b1;
                            data_setup_new <= result;
                        end
                    end
                end else if (key_valid && is_digit) begin
                    case (state)
                        S_BIPON: if (key_code <= 4'd1) begin
                            dig[0] <= key_code;
                            cnt    <= 3'd1;
                        end
                        S_BIPT, S_TRAVT: begin
                            dig[1] <= dig[0];
                            dig[0] <= key_code;
                            cnt    <= cnt == 3'd2 ? 3'd2 : cnt + 3'd1;
                        end
                        default: if (cnt < 3'd4) begin
                            dig[cnt[1:0]] <= key_code;
                            cnt           <= cnt + 3'd1;
                        end
                    endcase
                end
            endcase
        end
    end

endmodule
